// File: rtl/at_state_timer.sv
// Dwell timer: counts cycles while en holds, flags done/expired at a latched limit.
// Latency: outputs registered, one edge after the qualifying input; no backpressure.
// Optional prescaler built when AT_STATE_TIMER_PRESCALE_EN is defined.
module at_state_timer #(
  parameter int unsigned WIDTH         = 3,
  parameter int unsigned DEFAULT_LIMIT = 5,
  parameter int unsigned WRAP          = 0,
  parameter int unsigned PRESCALE      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             done,
  output logic             expired
);

  localparam logic [WIDTH-1:0] DEF_LIM = WIDTH'(DEFAULT_LIMIT);

  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] count_inc;
  logic             step;

  assign count_inc = count + WIDTH'(1);

`ifdef AT_STATE_TIMER_PRESCALE_EN
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc;

  assign step = (presc == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (clr || !en || step) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end
`else
  assign step = 1'b1;
`endif

  // limit_q only tracks the input outside a dwell so mid-dwell edits cannot shorten it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      done    <= 1'b0;
      expired <= 1'b0;
      limit_q <= DEF_LIM;
    end else begin
      if (!en) begin
        limit_q <= limit;
      end

      if (clr || !en || (limit_q == '0)) begin
        count   <= '0;
        done    <= 1'b0;
        expired <= 1'b0;
      end else if (step) begin
        if (count < limit_q) begin
          count   <= count_inc;
          done    <= (count_inc == limit_q);
          expired <= (count_inc == limit_q);
        end else if (WRAP != 0) begin
          count   <= '0;
          done    <= 1'b0;
          expired <= 1'b0;
        end else begin
          count   <= limit_q;
          done    <= 1'b1;
          expired <= 1'b0;
        end
      end else begin
        expired <= 1'b0;
      end
    end
  end

endmodule

// File: doc/at_state_timer.md
# at_state_timer

Parametrised successor to the interlock's at-state counter. It counts clock cycles while the controller holds an "at state" qualifier, and raises a one-cycle `expired` pulse and a level `done` flag when a programmable dwell limit is reached. It restarts whenever the qualifier drops. It sits beside the interlock FSM, which uses `done`/`expired` to time door and pressure states. Width, default limit and saturate/wrap mode are configurable.

## Interface
- `WIDTH`, 3: counter and limit width in bits.
- `DEFAULT_LIMIT`, 5: reset value of the internal limit register.
- `WRAP`, 0: 0 = saturate at limit; 1 = wrap to 0 after limit.
- `PRESCALE`, 4: cycles per count step; used only with the macro below, must be ≥ 1.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `en`  in  1  at-state qualifier; counting runs while high.
- `clr`  in  1  synchronous clear; priority over `en`.
- `limit`  in  WIDTH  dwell limit; captured only while `en` is low.
- `count`  out  WIDTH  current dwell count.
- `done`  out  1  high while `count == limit_q` and `limit_q != 0`.
- `expired`  out  1  one-cycle pulse on the edge where `count` becomes `limit_q`.

## Operation
- Reset (async, any time, including mid-count) drives the following values:
  - `count = 0`, `done = 0`, `expired = 0`.
  - `limit_q = DEFAULT_LIMIT`.
  - prescaler = 0.
- `limit_q` loads `limit` on every edge where `en == 0`. It is frozen while `en == 1`, so mid-dwell changes to `limit` are ignored.
- Per edge, priority order:
  1. `clr`: `count ← 0`; `done` and `expired` are 0 next cycle. `limit_q` follows the `en` rule.
  2. `en == 0`: `count ← 0`, `done ← 0`, `expired ← 0`.
  3. `limit_q == 0`: timer disabled. `count` holds 0; `done` and `expired` stay 0.
  4. `count < limit_q`: `count ← count + 1`. `expired ← 1` iff the new count equals `limit_q`.
  5. `count == limit_q`:
     - `WRAP = 0`: count holds and `expired ← 0`.
     - `WRAP = 1`: `count ← 0` and `expired ← 0`.
- `done` and `expired` are registered. There is no combinational path from inputs to outputs.
- Arithmetic is unsigned WIDTH-bit. `limit_q = 2^WIDTH − 1` is legal; `count` never exceeds `limit_q`.
- In wrap mode the period is `limit_q + 1` counted steps, with one `expired` per period.

## Timing
- With `en` high from edge 0, `count` reads k after edge k (no prescale).
- `expired` and `done` go high in the same cycle as `count == limit_q`.
- `expired` is exactly one cycle wide.
- `en` falling is seen on the next edge: `count`, `done` and `expired` are all 0 one cycle later.
- `clr` and `en` both high clears and does not increment. Counting resumes on the following edge if `en` stays high.
- `rst` takes effect immediately, without a clock edge. The first count step after release happens on the first edge with `en` high.

## Configuration
- `AT_STATE_TIMER_PRESCALE_EN` defined:
  - An internal `$clog2(PRESCALE)`-bit prescaler is built. It increments each enabled edge.
  - A count step (rules 4–5) occurs only on the edge where the prescaler equals `PRESCALE − 1`; the prescaler then returns to 0.
  - The prescaler clears on `rst`, on `clr`, and whenever `en == 0`.
  - `done` and `expired` follow count steps only.
- Not defined: no prescaler logic is built, every enabled edge is a count step, and `PRESCALE` is ignored.

## Test plan
- Reset: assert `rst` asynchronously mid-count (`count = 3`) → `count`, `done` and `expired` are 0 with no clock edge. After release with `en` low, `limit_q = 5`.
- Saturate (WIDTH 3, `limit = 5`, WRAP 0): `en` high 8 edges → `count` 1,2,3,4,5,5,5,5. `expired` high only after edge 5; `done` high from edge 5 on.
- Wrap (WRAP 1, `limit = 2`): `en` high 6 edges → `count` 1,2,0,1,2,0. `expired` after edges 2 and 5.
- Restart and clear:
  - `en` drops at `count = 3` → next cycle `count = 0`, `done = 0`.
  - `clr` together with `en` at `count = 4` → `count = 0`; next edges give 1,2.
- Limit freeze:
  - With `en` high at `count = 2`, change `limit` 5→1 → counting continues to 5.
  - After `en` low for one edge, a new dwell saturates at 1.
  - `limit = 0` → `count` stays 0; `done` and `expired` never assert.
- Prescale (macro defined, `PRESCALE = 4`, `limit = 2`):
  - `en` high → `count` = 1 after edge 4 and 2 after edge 8, with `expired` pulsing after edge 8.
  - Dropping `en` at edge 6 → prescaler and `count` return to 0.
